// File: rtl/axi_lite_cmd_master_if.sv
// axi_lite_cmd_master_if: AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views
interface AXI_BUS #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport Master (
        output aw_addr, aw_prot, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input  b_resp, b_valid, output b_ready,
        output ar_addr, ar_prot, ar_valid, input ar_ready,
        input  r_data, r_resp, r_valid, output r_ready
    );

    modport Slave (
        input  aw_addr, aw_prot, aw_valid, output aw_ready,
        input  w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input  ar_addr, ar_prot, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: turns single register commands into AXI4-Lite write/read transactions
// Ports:
//   clk_i, rstn_i             clock (rising edge), asynchronous active-low reset
//   axi                       AXI4-Lite master port
//   cmd_valid_i/cmd_ready_o   command handshake; cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i payload
//   rsp_valid_o/rsp_ready_i   response handshake; rsp_write_o, rsp_rdata_o, rsp_resp_o payload
//   err_cnt_o                 saturating count of non-OKAY responses
module axi_lite_cmd_master #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int ERRCNT_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    AXI_BUS.Master                    axi,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic                      rsp_write_o,
    output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic [1:0]                rsp_resp_o,
    output logic [ERRCNT_WIDTH-1:0]   err_cnt_o
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_RESP = 3'd4;
    localparam logic [2:0] RSP     = 3'd5;

    logic [2:0]              state_q, state_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic [ERRCNT_WIDTH-1:0] err_q, err_d;
    logic                    cmd_hs, b_hs, r_hs, capture;
    logic [1:0]              resp_in;

    assign cmd_ready_o = state_q == IDLE;
    assign cmd_hs      = cmd_valid_i && cmd_ready_o;
    assign b_hs        = state_q == WR_RESP && axi.b_valid;
    assign r_hs        = state_q == RD_RESP && axi.r_valid;
    assign capture     = b_hs || r_hs;
    assign resp_in     = b_hs ? axi.b_resp : axi.r_resp;

    // AW and W each drop once their own handshake is recorded
    assign axi.aw_valid = state_q == WR_REQ && !aw_done_q;
    assign axi.aw_addr  = addr_q;
    assign axi.aw_prot  = 3'b000;
    assign axi.w_valid  = state_q == WR_REQ && !w_done_q;
    assign axi.w_data   = wdata_q;
    assign axi.w_strb   = wstrb_q;
    assign axi.b_ready  = state_q == WR_RESP;
    assign axi.ar_valid = state_q == RD_REQ;
    assign axi.ar_addr  = addr_q;
    assign axi.ar_prot  = 3'b000;
    assign axi.r_ready  = state_q == RD_RESP;

    assign rsp_valid_o = state_q == RSP;
    assign rsp_write_o = write_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_resp_o  = resp_q;
    assign err_cnt_o   = err_q;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (cmd_hs) state_d = cmd_write_i ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                aw_done_d = aw_done_q || axi.aw_ready;
                w_done_d  = w_done_q || axi.w_ready;
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: if (b_hs) state_d = RSP;
            RD_REQ:  if (axi.ar_ready) state_d = RD_RESP;
            RD_RESP: if (r_hs) state_d = RSP;
            RSP:     if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        write_d = cmd_hs ? cmd_write_i : write_q;
        addr_d  = cmd_hs ? cmd_addr_i : addr_q;
        wdata_d = cmd_hs ? cmd_wdata_i : wdata_q;
        wstrb_d = cmd_hs ? cmd_wstrb_i : wstrb_q;
        rdata_d = r_hs ? axi.r_data : (b_hs ? '0 : rdata_q);
        resp_d  = capture ? resp_in : resp_q;
        err_d   = (capture && resp_in != 2'b00 && err_q != '1) ? err_q + 1'b1 : err_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            err_q     <= err_d;
        end
    end
endmodule
